conv_mac_pipe: RTL and testbench
================================

CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 SHALL have parameter KSIZE, default 5, kernel edge; the block has KK=KSIZE*KSIZE taps.
REQ-002 SHALL have parameter DW, default 8, unsigned input pixel width.
REQ-003 SHALL have parameter WW, default 8, signed weight width.
REQ-004 SHALL have parameter NCH, default 4, number of output channels sharing one input window.
REQ-005 SHALL have parameter ACCW, default 32, signed accumulator width.
REQ-006 SHALL have parameter SHIFT, default 7, requantisation right-shift.
REQ-007 SHALL have parameter RELU, default 1: 1 = unsigned [0,255] output, 0 = signed [-128,127] output.
REQ-008 SHALL have parameter WEIGHT_FILE, default "", hex init file, ordered ch0 tap0..tap KK-1, then ch1, and so on.
REQ-009 SHALL have port clk, input, 1, clock.
REQ-010 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-011 SHALL have ports in_valid input 1 and in_ready output 1, input handshake.
REQ-012 SHALL have port in_data, input, KK*DW, window with tap 0 in the LSBs and row-major order.
REQ-013 SHALL have ports w_we input 1, w_ch input clog2(NCH), w_idx input clog2(KK), w_data input WW, runtime weight write.
REQ-014 SHALL have ports b_we input 1 and b_data input ACCW, bias write to channel w_ch.
REQ-015 SHALL have port w_ack, output, 1, one-cycle pulse when a weight or bias write is accepted.
REQ-016 SHALL have ports out_valid output 1 and out_ready input 1, output handshake.
REQ-017 SHALL have port out_data, output, NCH*8, with channel 0 in the LSBs.
REQ-018 SHALL have port busy, output, 1, high when any pipeline stage holds valid data.

Function
REQ-019 SHALL use 4 stages: S1 multiply KK*NCH products; S2 per channel, KSIZE row partial sums; S3 sum of rows plus bias; S4 round, shift and clamp into the output register.
REQ-020 SHALL have a latency of exactly 4 cycles from the accepting edge (in_valid&&in_ready) to out_valid, with no stall.
REQ-021 SHALL sustain a throughput of 1 window per cycle while out_ready=1.
REQ-022 SHALL use a global stall: adv = !out_valid || out_ready; in_ready = adv, combinational; no stage register changes while adv=0.
REQ-023 SHALL hold out_valid and out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL propagate bubbles (in_valid=0 while adv=1) as invalid stages; no spurious out_valid.
REQ-025 SHALL zero-extend pixels to DW+1 bits, sign-extend weights, and form products and sums in ACCW-bit two's complement, wrapping on overflow.
REQ-026 SHALL compute raw = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic; when SHIFT=0, raw = sum.
REQ-027 SHALL clamp raw to [0,255] when RELU=1, else to [-128,127] encoded as two's complement.
REQ-028 SHALL accept a weight or bias write only when busy=0 and in_valid=0; otherwise the write is dropped and w_ack stays 0.
REQ-029 SHALL, when w_we and b_we are both high, write both in the same cycle and pulse w_ack once.
REQ-030 SHALL ignore writes with w_ch>=NCH or w_idx>=KK (no write, no w_ack).
REQ-031 SHALL apply an accepted write to every window accepted on a later cycle.

Reset
REQ-032 SHALL, on rst_n=0, clear all stage valids, out_valid, out_data, w_ack and bias registers to 0 immediately.
REQ-033 SHALL not reset the weight memory: it keeps the WEIGHT_FILE contents or the last written values (zero if no file).
REQ-034 SHALL discard in-flight windows on reset mid-operation; the first out_valid after release occurs 4 cycles after a new accept.

Verification
REQ-035 KSIZE=5, NCH=2, all pixels 128, ch0 weights +1, ch1 weights -1, bias 0 -> after 4 cycles out_data[7:0]=25, out_data[15:8]=0.
REQ-036 All pixels 255, all weights 127 -> sum 809625 -> out 255 (saturation); RELU=0 same stimulus -> 127; weights -128 -> -128 (0x80).
REQ-037 Weights 0, bias write 1000 to ch1 -> ch1 out 8, ch0 out 0, w_ack pulses one cycle.
REQ-038 6 back-to-back windows, out_ready=0 from the first out_valid for 5 cycles -> in_ready low while stalled, out_data held, all 6 results delivered in order with none lost or duplicated.
REQ-039 Weight write issued while busy=1 -> w_ack=0 and results unchanged; reissued when idle -> w_ack=1 and the next window uses the new weight.
REQ-040 rst_n pulsed low with 3 windows in flight -> out_valid=0, busy=0 immediately, no stale output after release.

Source files
------------

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: 4-stage multi-channel KSIZE x KSIZE convolution MAC with
// requantisation. A single pixel window is shared by NCH output channels.
// All pipeline stages share one stall signal.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     window handshake (in_ready is combinational)
//   in_data               KK pixels, tap 0 in the LSBs, row-major
//   w_we/w_ch/w_idx/w_data  runtime weight write
//   b_we/b_data           bias write to channel w_ch
//   w_ack                 one-cycle pulse for each accepted write
//   out_valid/out_ready   result handshake
//   out_data              NCH 8-bit results, channel 0 in the LSBs
//   busy                  any pipeline stage holds a valid window
module conv_mac_pipe #(
  parameter int unsigned KSIZE       = 5,
  parameter int unsigned DW          = 8,
  parameter int unsigned WW          = 8,
  parameter int unsigned NCH         = 4,
  parameter int unsigned ACCW        = 32,
  parameter int unsigned SHIFT       = 7,
  parameter int unsigned RELU        = 1,
  parameter string       WEIGHT_FILE = "",
  localparam int unsigned KK   = KSIZE * KSIZE,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned IDXW = (KK > 1) ? $clog2(KK) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [KK*DW-1:0]      in_data,
  input  logic                  w_we,
  input  logic [CHW-1:0]        w_ch,
  input  logic [IDXW-1:0]       w_idx,
  input  logic [WW-1:0]         w_data,
  input  logic                  b_we,
  input  logic [ACCW-1:0]       b_data,
  output logic                  w_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*8-1:0]      out_data,
  output logic                  busy
);

  localparam int unsigned NW = NCH * KK;
  localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;
  // Rounding constant added before the arithmetic shift (zero when SHIFT=0).
  localparam logic signed [ACCW-1:0] RND =
    (SHIFT == 0) ? '0 : (ACCW'(1) << (SHIFT - 1));

  // Weight memory: not reset, so it survives rst_n.
  logic [WW-1:0] wmem [NW];

  logic signed [ACCW-1:0] bias_q [NCH];

  logic signed [ACCW-1:0] prod_d [NCH][KK];
  logic signed [ACCW-1:0] prod_q [NCH][KK];
  logic signed [ACCW-1:0] row_d  [NCH][KSIZE];
  logic signed [ACCW-1:0] row_q  [NCH][KSIZE];
  logic signed [ACCW-1:0] sum_d  [NCH];
  logic signed [ACCW-1:0] sum_q  [NCH];

  logic              v1_q, v2_q, v3_q;
  logic              out_valid_q;
  logic [NCH*8-1:0]  out_data_d, out_data_q;
  logic              w_ack_q;

  logic              adv;
  logic              wr_range;
  logic              wr_ok;
  logic [AW-1:0]     w_addr;

  // Global stall: everything advances unless a result is waiting for out_ready.
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign busy      = v1_q || v2_q || v3_q || out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign w_ack     = w_ack_q;

  // Write acceptance: only when idle, no window offered, and address in range.
  assign wr_range = (32'(w_ch) < NCH) && (32'(w_idx) < KK);
  assign wr_ok    = (w_we || b_we) && !busy && !in_valid && wr_range;
  assign w_addr   = AW'(32'(w_ch) * KK + 32'(w_idx));

  // Weight memory write port.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NW; i++) begin
      if (wr_ok && w_we && (w_addr == AW'(i))) wmem[i] <= w_data;
    end
  end

  // S1: products of zero-extended pixels and sign-extended weights.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned t = 0; t < KK; t++) begin
        prod_d[c][t] = ACCW'($signed({1'b0, in_data[t*DW +: DW]})) *
                       ACCW'($signed(wmem[c*KK + t]));
      end
    end
  end

  // S2: per-channel row partial sums.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      for (int unsigned r = 0; r < KSIZE; r++) begin
        row_d[c][r] = '0;
        for (int unsigned k = 0; k < KSIZE; k++) begin
          row_d[c][r] = row_d[c][r] + prod_q[c][r*KSIZE + k];
        end
      end
    end
  end

  // S3: sum of rows plus channel bias.
  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      sum_d[c] = bias_q[c];
      for (int unsigned r = 0; r < KSIZE; r++) begin
        sum_d[c] = sum_d[c] + row_q[c][r];
      end
    end
  end

  // S4: round, arithmetic shift and clamp to 8 bits.
  always_comb begin
    logic signed [ACCW-1:0] raw;
    out_data_d = '0;
    raw        = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      raw = (sum_q[c] + RND) >>> SHIFT;
      if (RELU != 0) begin
        if (raw < 0)        out_data_d[c*8 +: 8] = 8'h00;
        else if (raw > 255) out_data_d[c*8 +: 8] = 8'hFF;
        else                out_data_d[c*8 +: 8] = raw[7:0];
      end else begin
        if (raw < -128)     out_data_d[c*8 +: 8] = 8'h80;
        else if (raw > 127) out_data_d[c*8 +: 8] = 8'h7F;
        else                out_data_d[c*8 +: 8] = raw[7:0];
      end
    end
  end

  // Control, bias and output registers (reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      w_ack_q     <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) bias_q[c] <= '0;
    end else begin
      w_ack_q <= wr_ok;
      for (int unsigned c = 0; c < NCH; c++) begin
        if (wr_ok && b_we && (w_ch == CHW'(c))) bias_q[c] <= b_data;
      end
      if (adv) begin
        v1_q        <= in_valid;
        v2_q        <= v1_q;
        v3_q        <= v2_q;
        out_valid_q <= v3_q;
        if (v3_q) out_data_q <= out_data_d;
      end
    end
  end

  // Datapath stage registers (no reset; qualified by the valid bits).
  always_ff @(posedge clk) begin
    if (adv) begin
      prod_q <= prod_d;
      row_q  <= row_d;
      sum_q  <= sum_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe (KSIZE=5, NCH=2); a RELU=1 and a RELU=0
// instance receive identical stimulus.
module tb_conv_mac_pipe;

  localparam int unsigned KK = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid, out_ready, w_we, b_we;
  logic [KK*8-1:0]   in_data;
  logic [0:0]        w_ch;
  logic [4:0]        w_idx;
  logic [7:0]        w_data;
  logic [31:0]       b_data;

  logic              in_ready, w_ack, out_valid, busy;
  logic [15:0]       out_data;
  logic              in_ready_s, w_ack_s, out_valid_s, busy_s;
  logic [15:0]       out_data_s;

  int checks = 0;
  int errors = 0;

  conv_mac_pipe #(.KSIZE(5), .NCH(2), .RELU(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_we(w_we), .w_ch(w_ch), .w_idx(w_idx),
    .w_data(w_data), .b_we(b_we), .b_data(b_data), .w_ack(w_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy));

  conv_mac_pipe #(.KSIZE(5), .NCH(2), .RELU(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .w_we(w_we), .w_ch(w_ch), .w_idx(w_idx),
    .w_data(w_data), .b_we(b_we), .b_data(b_data), .w_ack(w_ack_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .busy(busy_s));

  function automatic logic [KK*8-1:0] fill(input logic [7:0] p);
    logic [KK*8-1:0] r;
    for (int i = 0; i < KK; i++) r[i*8 +: 8] = p;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int ch, input logic [7:0] v);
    for (int i = 0; i < KK; i++) begin
      w_ch = 1'(ch); w_idx = 5'(i); w_data = v; w_we = 1'b1;
      tick();
    end
    w_we = 1'b0;
  endtask

  task automatic run_window(input logic [KK*8-1:0] d, output logic [15:0] o1,
                            output logic [15:0] o2, output int lat);
    in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    o1 = out_data;
    o2 = out_data_s;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 1; w_we = 0; b_we = 0; in_data = '0;
    w_ch = 0; w_idx = 0; w_data = 0; b_data = 0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b want 0", out_valid, out_valid_s); end
    checks++; if (busy !== 1'b0 || busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0", busy, busy_s); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    checks++; if (w_ack !== 1'b0 || w_ack_s !== 1'b0) begin errors++; $display("FAIL reset_w_ack got %b want 0", w_ack); end
    checks++; if (in_ready !== 1'b1 || in_ready_s !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] o1, o2; int lat;
    set_w(0, 8'h01); set_w(1, 8'hFF);
    run_window(fill(8'd128), o1, o2, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++; if (o1 !== 16'h0019) begin errors++; $display("FAIL basic_relu got %h want 0019", o1); end
    checks++; if (o2 !== 16'hE719) begin errors++; $display("FAIL basic_signed got %h want e719", o2); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_drain got v=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_saturation();
    logic [15:0] o1, o2; int lat;
    set_w(0, 8'h7F); set_w(1, 8'h7F);
    run_window(fill(8'd255), o1, o2, lat);
    checks++; if (o1 !== 16'hFFFF) begin errors++; $display("FAIL sat_pos_relu got %h want ffff", o1); end
    checks++; if (o2 !== 16'h7F7F) begin errors++; $display("FAIL sat_pos_signed got %h want 7f7f", o2); end
    set_w(0, 8'h80); set_w(1, 8'h80);
    run_window(fill(8'd255), o1, o2, lat);
    checks++; if (o1 !== 16'h0000) begin errors++; $display("FAIL sat_neg_relu got %h want 0000", o1); end
    checks++; if (o2 !== 16'h8080) begin errors++; $display("FAIL sat_neg_signed got %h want 8080", o2); end
  endtask

  task automatic test_bias();
    logic [15:0] o1, o2; int lat;
    set_w(0, 8'h00); set_w(1, 8'h00);
    w_ch = 1'b1; w_idx = 5'd0; b_data = 32'd1000; b_we = 1'b1;
    tick();
    b_we = 1'b0;
    checks++; if (w_ack !== 1'b1) begin errors++; $display("FAIL bias_ack got %b want 1", w_ack); end
    tick();
    checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL bias_ack_pulse got %b want 0", w_ack); end
    run_window(fill(8'd128), o1, o2, lat);
    checks++; if (o1 !== 16'h0800 || o2 !== 16'h0800) begin errors++; $display("FAIL bias_out got %h/%h want 0800", o1, o2); end
    // out-of-range tap index must be dropped
    w_ch = 1'b0; w_idx = 5'd25; w_data = 8'd5; w_we = 1'b1;
    tick();
    w_we = 1'b0;
    checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL range_ack got %b want 0", w_ack); end
    // simultaneous weight + bias write, single ack
    w_ch = 1'b0; w_idx = 5'd0; w_data = 8'd2; b_data = 32'd0; w_we = 1'b1; b_we = 1'b1;
    tick();
    w_we = 1'b0; b_we = 1'b0;
    checks++; if (w_ack !== 1'b1) begin errors++; $display("FAIL dual_ack got %b want 1", w_ack); end
    tick();
    checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL dual_ack_pulse got %b want 0", w_ack); end
    run_window(fill(8'd128), o1, o2, lat);
    checks++; if (o1 !== 16'h0802) begin errors++; $display("FAIL dual_out got %h want 0802", o1); end
    w_ch = 1'b1; b_data = 32'd0; b_we = 1'b1;
    tick();
    b_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sent, got, stall, cyc, expv;
    bit seen, held_ok;
    logic [15:0] held;
    set_w(0, 8'h01); set_w(1, 8'h00);
    sent = 0; got = 0; stall = 0; cyc = 0; seen = 0; held_ok = 0; held = '0;
    while (got < 6 && cyc < 60) begin
      if (out_valid && !seen) begin seen = 1; stall = 5; end
      if (stall > 0) begin out_ready = 1'b0; stall--; end
      else out_ready = 1'b1;
      if (sent < 6) begin in_valid = 1'b1; in_data = fill(8'(20 * (sent + 1))); end
      else in_valid = 1'b0;
      #1;
      if (!out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
        if (held_ok) begin
          checks++; if (out_data !== held) begin errors++; $display("FAIL b2b_hold got %h want %h", out_data, held); end
        end
        held = out_data; held_ok = 1;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        expv = (25 * 20 * (got + 1) + 64) >> 7;
        checks++; if (out_data !== 16'(expv)) begin errors++; $display("FAIL b2b_data%0d got %h want %h", got, out_data, 16'(expv)); end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 6 || sent != 6) begin errors++; $display("FAIL b2b_count got sent=%0d got=%0d want 6/6", sent, got); end
    repeat (5) tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_extra got v=%b busy=%b want 0/0", out_valid, busy); end
  endtask

  task automatic test_busy_write();
    logic [15:0] o1, o2; int lat, n;
    in_data = fill(8'd128); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bw_busy got %b want 1", busy); end
    w_ch = 1'b0; w_idx = 5'd0; w_data = 8'd50; w_we = 1'b1;
    tick();
    w_we = 1'b0;
    checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL bw_drop_ack got %b want 0", w_ack); end
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0019) begin errors++; $display("FAIL bw_unchanged got v=%b %h want 1 0019", out_valid, out_data); end
    tick();
    w_we = 1'b1;
    tick();
    w_we = 1'b0;
    checks++; if (w_ack !== 1'b1) begin errors++; $display("FAIL bw_idle_ack got %b want 1", w_ack); end
    run_window(fill(8'd128), o1, o2, lat);
    checks++; if (o1 !== 16'h004A || lat !== 4) begin errors++; $display("FAIL bw_new_weight got %h lat %0d want 004a lat 4", o1, lat); end
  endtask

  task automatic test_reset_flight();
    logic [15:0] o1, o2; int lat;
    bit spurious;
    w_ch = 1'b0; b_data = 32'd1280; b_we = 1'b1;
    tick();
    b_we = 1'b0;
    in_data = fill(8'd128); in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rf_pre got v=%b busy=%b want 1/1", out_valid, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0000) begin errors++; $display("FAIL rf_async got v=%b busy=%b d=%h want 0/0/0000", out_valid, busy, out_data); end
    tick(); tick();
    rst_n = 1'b1;
    spurious = 0;
    repeat (8) begin tick(); if (out_valid !== 1'b0) spurious = 1; end
    checks++; if (spurious) begin errors++; $display("FAIL rf_stale got out_valid seen want none"); end
    run_window(fill(8'd128), o1, o2, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rf_latency got %0d want 4", lat); end
    checks++; if (o1 !== 16'h004A) begin errors++; $display("FAIL rf_data got %h want 004a", o1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_bias();
    test_back_to_back();
    test_busy_write();
    test_reset_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
